// File: rtl/frame_receiver_pkg.sv
// Sensor output bus geometry and receiver FSM encoding shared by the frame receiver.
package frame_receiver_pkg;
    localparam int PIXEL_ARRAY_WIDTH  = 8;
    localparam int PIXEL_ARRAY_HEIGHT = 4;
    localparam int OUTPUT_BUS_WIDTH   = 2;
    localparam int PIXEL_BITS         = 8;
    localparam int WORDS_PER_ROW      = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
    localparam int FRAME_COUNT_BITS   = 16;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_RECV,
        RX_HOLD
    } rx_state_t;
endpackage

// File: rtl/frame_receiver_edge_detect.sv
// Registers a level input and flags the cycle after it is first sampled high.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);
    logic sample;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sample <= 1'b0;
            prev   <= 1'b0;
        end else begin
            sample <= level;
            prev   <= sample;
        end
    end

    assign pulse = sample & ~prev;
endmodule

// File: rtl/frame_receiver.sv
// Reassembles sensor bus words into rows, hands rows off via valid/ready,
// and tracks rows, frames and sticky overrun / sync errors.
module frame_receiver #(
    parameter int PIXEL_ARRAY_WIDTH  = frame_receiver_pkg::PIXEL_ARRAY_WIDTH,
    parameter int PIXEL_ARRAY_HEIGHT = frame_receiver_pkg::PIXEL_ARRAY_HEIGHT,
    parameter int OUTPUT_BUS_WIDTH   = frame_receiver_pkg::OUTPUT_BUS_WIDTH,
    parameter int PIXEL_BITS         = frame_receiver_pkg::PIXEL_BITS
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              output_clk,
    input  logic [OUTPUT_BUS_WIDTH-1:0][PIXEL_BITS-1:0]       data_in,
    input  logic                                              pixel_frame_finished,
    input  logic                                              row_ready,
    input  logic                                              err_clear,
    output logic                                              row_valid,
    output logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0]      row_data,
    output logic [$clog2(PIXEL_ARRAY_HEIGHT)-1:0]             row_index,
    output logic                                              frame_done,
    output logic [15:0]                                       frame_count,
    output logic                                              overrun,
    output logic                                              sync_error
);
    import frame_receiver_pkg::*;

    localparam int ROW_WORDS = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
    localparam int COL_W     = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
    localparam int ROW_W     = $clog2(PIXEL_ARRAY_HEIGHT);

    logic beat;
    logic sync;
    rx_state_t state;
    logic [COL_W-1:0] col, col_eff;
    logic [ROW_W-1:0] row, row_eff;
    logic realign;
    logic [ROW_WORDS-1:0][OUTPUT_BUS_WIDTH-1:0][PIXEL_BITS-1:0] row_buf;

    edge_detect u_strobe (.clk(clk), .reset(reset), .level(output_clk),           .pulse(beat));
    edge_detect u_sync   (.clk(clk), .reset(reset), .level(pixel_frame_finished), .pulse(sync));

    assign row_data = row_buf;

    // Outside HOLD a sync realigns before the same-cycle beat is placed.
    always_comb begin
        col_eff = col;
        row_eff = row;
        if (sync && state != RX_HOLD) begin
            col_eff = '0;
            row_eff = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RX_IDLE;
            col         <= '0;
            row         <= '0;
            realign     <= 1'b0;
            row_buf     <= '0;
            row_valid   <= 1'b0;
            row_index   <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            overrun     <= 1'b0;
            sync_error  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (err_clear) begin
                overrun    <= 1'b0;
                sync_error <= 1'b0;
            end
            case (state)
                RX_HOLD: begin
                    if (beat) overrun <= 1'b1;
                    if (sync) realign <= 1'b1;
                    if (row_ready) begin
                        row_valid <= 1'b0;
                        col       <= '0;
                        if (realign || sync) begin
                            row     <= '0;
                            realign <= 1'b0;
                            state   <= RX_IDLE;
                        end else if (row == ROW_W'(PIXEL_ARRAY_HEIGHT - 1)) begin
                            row         <= '0;
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 1'b1;
                            state       <= RX_IDLE;
                        end else begin
                            row   <= row + 1'b1;
                            state <= RX_RECV;
                        end
                    end
                end
                default: begin
                    if (sync && (col != '0 || row != '0)) sync_error <= 1'b1;
                    row <= row_eff;
                    if (beat) begin
                        row_buf[col_eff] <= data_in;
                        if (col_eff == COL_W'(ROW_WORDS - 1)) begin
                            col       <= '0;
                            row_valid <= 1'b1;
                            row_index <= row_eff;
                            state     <= RX_HOLD;
                        end else begin
                            col   <= col_eff + 1'b1;
                            state <= RX_RECV;
                        end
                    end else if (sync) begin
                        col   <= '0;
                        state <= RX_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/frame_receiver.md
# frame_receiver

Receiver end of the sensor output bus. Consumes the `OUTPUT_BUS_WIDTH`-pixel words that the sensor presents with its `output_clk` strobe and reassembles them into full pixel rows. Completed rows are handed to downstream logic through a valid/ready handshake, and the block counts rows and frames. It sits between the sensor top and any frame consumer (image store, test readout), entirely in the system `clk` domain.

## Interface
Parameters (defaults taken from `PixelSensorConfig`):
- `PIXEL_ARRAY_WIDTH`, package value: pixels per row; must be a multiple of `OUTPUT_BUS_WIDTH`.
- `PIXEL_ARRAY_HEIGHT`, package value: rows per frame.
- `OUTPUT_BUS_WIDTH`, package value: pixels per bus word.
- `PIXEL_BITS`, package value: bits per pixel.

Ports:
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `output_clk` input 1: sensor word strobe, level-sampled on `clk`.
- `data_in` input `[OUTPUT_BUS_WIDTH-1:0][PIXEL_BITS-1:0]`: sensor word.
- `pixel_frame_finished` input 1: sensor frame marker; its rising edge realigns the receiver to the frame start.
- `row_ready` input 1: downstream accepts the held row.
- `err_clear` input 1: clears the sticky error flags.
- `row_valid` output 1: a complete row is held.
- `row_data` output `[PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0]`: the held row.
- `row_index` output `$clog2(PIXEL_ARRAY_HEIGHT)`: row number of the held row.
- `frame_done` output 1: one-cycle pulse when the last row of a frame is accepted.
- `frame_count` output 16: number of completed frames; wraps.
- `overrun` output 1: sticky; a word arrived while a row was held.
- `sync_error` output 1: sticky; a frame marker arrived mid-frame.

## Operation
- **Beat detection**
  - `output_clk` and `pixel_frame_finished` are registered.
  - A beat is a cycle with sampled `output_clk`=1 and previous sample 0.
  - A sync is the same rising-edge condition on `pixel_frame_finished`.
- **Word placement:** on a beat, `data_in[i]` is written to `row_buf[col*OUTPUT_BUS_WIDTH+i]`, and `col` increments. `WORDS_PER_ROW = PIXEL_ARRAY_WIDTH/OUTPUT_BUS_WIDTH`.
- **States**
  - IDLE: after reset; `col=0`, `row=0`. A beat writes word 0 and moves to RECV, or straight to HOLD if `WORDS_PER_ROW`=1.
  - RECV: accepts beats. The beat carrying word `WORDS_PER_ROW-1` sets `col=0`, sets `row_valid`, and moves to HOLD.
  - HOLD: `row_valid`=1. `row_data` and `row_index` are stable.
    - A beat in HOLD is dropped and sets `overrun`.
    - On `row_valid && row_ready`: `row_valid` drops next cycle and the state returns to RECV.
    - If that accepted row has index `PIXEL_ARRAY_HEIGHT-1`: `row` wraps to 0, `frame_done` pulses, `frame_count` increments, and the state goes to IDLE. Otherwise `row` increments.
- **Sync handling:** a sync with `col!=0`, or with `row!=0` while not in HOLD, sets `sync_error`, discards the partial row, and forces `col=0`, `row=0`, IDLE.
  - Sync in HOLD: the held row is still delivered. The realignment applies at the accept, with no `frame_done` and no `frame_count` increment.
- **Simultaneous events**
  - Sync and beat in the same cycle: the sync is applied first, then the beat is written as word 0 of row 0.
  - `err_clear` and a new error in the same cycle: the flag stays set.
  - Accept and beat in the same cycle: the beat counts as overrun, because the state is still HOLD.
- **Reset values:** every output is 0. Internal `col`, `row` and edge registers are 0. `row_buf` content is don't-care but `row_data` must read 0.

## Timing
- Beat-to-capture latency:
  - The edge where `output_clk` is first sampled high registers the sample.
  - `data_in` is captured on the following edge.
  - The sensor holds `data_in` stable from the `output_clk` rise until 2 `clk` cycles later.
  - `output_clk` high and low phases are each at least 2 `clk` cycles.
- `row_valid` rises on the same edge that captures the final word of the row.
- `row_valid` falls on the first edge at which `row_ready`=1 is sampled.
- `frame_done` is high for exactly the cycle after that accept.
- Minimum time between accepted rows: `WORDS_PER_ROW` beats.

## Structure
- `PixelSensorConfig` gains:
  - `WORDS_PER_ROW`;
  - the state enum `rx_state_t` {RX_IDLE, RX_RECV, RX_HOLD};
  - `FRAME_COUNT_BITS`=16.
- One sub-module, `edge_detect`: a registered rising-edge pulse, instantiated twice (strobe and sync).
- Row buffer, counters and FSM live in `frame_receiver`.

## Test plan
Bench config: W=4, H=2, BUS=2, BITS=8, `row_ready` tied high unless stated.
- Reset, then four strobes carrying {01,02},{03,04},{05,06},{07,08} -> rows 0 and 1 = 01..04 and 05..08. `frame_done` pulses once, `frame_count`=1, no error flags.
- `row_ready`=0 after row 0, then one extra strobe {AA,BB} -> `overrun`=1 and `row_data` stays 01..04. Raise `row_ready` -> row 0 accepted; `err_clear` -> `overrun`=0.
- Two strobes, then a `pixel_frame_finished` rise mid-row -> `sync_error`=1. The next two words form row 0, and `row_index`=0.
- Sync rising in the same cycle as a strobe {11,22} -> the word is placed at pixels 0–1 of row 0, with no error if the receiver was idle.
- Assert `reset` while in HOLD -> next cycle all outputs 0 and state IDLE. A fresh frame then completes normally.
- Run 65 536 frames, or force the count -> `frame_count` wraps to 0.
